// File: rtl/spi_apb_sequencer.sv
// Turns one command word into the APB write burst that programs the SPI master,
// then follows pready_i through transfer start and completion.
//
// state         | meaning
// --------------+----------------------------------------------------------
// ST_IDLE       | ready for a command; illegal counts are rejected here
// ST_SETUP      | APB setup phase of the current write (psel=1, penable=0)
// ST_ACCESS     | APB access phase, held until pready_i=1
// ST_WAIT_START | burst finished, waiting for pready_i low (transfer start)
// ST_WAIT_DONE  | transfer running, waiting for pready_i high (completion)
module spi_apb_sequencer #(
   parameter int unsigned START_TMO = 4,
   parameter int unsigned DONE_TMO  = 1024
) (
   input  logic        pclk_i,
   input  logic        presetn_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic [7:0]  cmd_instr_i,
   input  logic [2:0]  cmd_cnt_i,
   input  logic [39:0] cmd_data_i,
   output logic [7:0]  paddr_o,
   output logic        psel_o,
   output logic        penable_o,
   output logic        pwrite_o,
   output logic [7:0]  pwdata_o,
   input  logic        pready_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_WAIT_START,
      ST_WAIT_DONE
   } state_t;

   localparam logic [15:0] START_LOAD = 16'(START_TMO - 1);
   localparam logic [15:0] DONE_LOAD  = 16'(DONE_TMO - 1);

   state_t      state_q;
   logic [7:0]  instr_q;
   logic [2:0]  cnt_q;
   logic [39:0] data_q;
   logic [2:0]  idx_q;
   logic [15:0] tmo_q;
   logic        psel_q;
   logic        penable_q;
   logic        pwrite_q;
   logic [7:0]  paddr_q;
   logic [7:0]  pwdata_q;
   logic        done_q;
   logic        err_q;

   // Write list entry idx: INSTR, BYTES_1..BYTES_cnt, BYTES_CNT, DRIVE.
   function automatic logic [15:0] wr_entry(input logic [2:0]  idx,
                                            input logic [2:0]  cnt,
                                            input logic [7:0]  instr,
                                            input logic [39:0] data);
      logic [7:0] byte_sel;
      case (idx)
         3'd1:    byte_sel = data[7:0];
         3'd2:    byte_sel = data[15:8];
         3'd3:    byte_sel = data[23:16];
         3'd4:    byte_sel = data[31:24];
         3'd5:    byte_sel = data[39:32];
         default: byte_sel = instr;
      endcase
      if (idx == 3'd0)
         return {8'h00, instr};
      else if (idx <= cnt)
         return {5'd0, idx, byte_sel};
      else if (idx == cnt + 3'd1)
         return {8'h06, 5'd0, cnt};
      else
         return {8'h07, 8'hFF};
   endfunction

   always_ff @(posedge pclk_i) begin
      if (!presetn_i) begin
         state_q   <= ST_IDLE;
         instr_q   <= 8'h00;
         cnt_q     <= 3'd0;
         data_q    <= 40'd0;
         idx_q     <= 3'd0;
         tmo_q     <= 16'd0;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= 8'h00;
         pwdata_q  <= 8'h00;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (cmd_valid_i) begin
                  instr_q <= cmd_instr_i;
                  cnt_q   <= cmd_cnt_i;
                  data_q  <= cmd_data_i;
                  if (cmd_cnt_i > 3'd5) begin
                     err_q <= 1'b1;
                  end else begin
                     state_q  <= ST_SETUP;
                     psel_q   <= 1'b1;
                     pwrite_q <= 1'b1;
                     paddr_q  <= 8'h00;
                     pwdata_q <= cmd_instr_i;
                     idx_q    <= 3'd0;
                  end
               end
            end
            ST_SETUP: begin
               penable_q <= 1'b1;
               state_q   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (pready_i) begin
                  penable_q <= 1'b0;
                  // DRIVE is always the last entry of the list
                  if (paddr_q == 8'h07) begin
                     state_q  <= ST_WAIT_START;
                     psel_q   <= 1'b0;
                     pwrite_q <= 1'b0;
                     paddr_q  <= 8'h00;
                     pwdata_q <= 8'h00;
                     tmo_q    <= START_LOAD;
                  end else begin
                     {paddr_q, pwdata_q} <= wr_entry(idx_q + 3'd1, cnt_q, instr_q, data_q);
                     idx_q   <= idx_q + 3'd1;
                     state_q <= ST_SETUP;
                  end
               end
            end
            ST_WAIT_START: begin
               if (!pready_i) begin
                  state_q <= ST_WAIT_DONE;
                  tmo_q   <= DONE_LOAD;
               end else if (tmo_q == 16'd0) begin
                  err_q   <= 1'b1;
                  state_q <= ST_IDLE;
               end else begin
                  tmo_q <= tmo_q - 16'd1;
               end
            end
            ST_WAIT_DONE: begin
               if (pready_i) begin
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end else if (tmo_q == 16'd0) begin
                  err_q   <= 1'b1;
                  state_q <= ST_IDLE;
               end else begin
                  tmo_q <= tmo_q - 16'd1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy_o      = (state_q != ST_IDLE);
   assign cmd_ready_o = ~busy_o;
   assign psel_o      = psel_q;
   assign penable_o   = penable_q;
   assign pwrite_o    = pwrite_q;
   assign paddr_o     = paddr_q;
   assign pwdata_o    = pwdata_q;
   assign done_o      = done_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_spi_apb_sequencer.sv
// Bench for spi_apb_sequencer: a pready responder plus a list/timing model
// of the expected APB burst and done/timeout outcome for each command.
module tb_spi_apb_sequencer;

   localparam int START_TMO = 4;
   localparam int DONE_TMO  = 16;

   logic        pclk = 1'b0;
   logic        presetn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_instr;
   logic [2:0]  cmd_cnt;
   logic [39:0] cmd_data;
   logic [7:0]  paddr;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [7:0]  pwdata;
   logic        pready;
   logic        busy;
   logic        done;
   logic        err;

   int checks   = 0;
   int failures = 0;

   spi_apb_sequencer #(.START_TMO(START_TMO), .DONE_TMO(DONE_TMO)) dut (
      .pclk_i(pclk), .presetn_i(presetn),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
      .cmd_instr_i(cmd_instr), .cmd_cnt_i(cmd_cnt), .cmd_data_i(cmd_data),
      .paddr_o(paddr), .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
      .pwdata_o(pwdata), .pready_i(pready),
      .busy_o(busy), .done_o(done), .err_o(err)
   );

   always #5 pclk = ~pclk;

   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      checks++;
      if ({psel, penable, pwrite, done, err, busy} !== 6'b0 || paddr !== 8'h00 ||
          pwdata !== 8'h00 || cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s: psel=%b pen=%b pwr=%b done=%b err=%b busy=%b paddr=%h pwdata=%h rdy=%b, required all 0 and rdy=1",
                  tag, psel, penable, pwrite, done, err, busy, paddr, pwdata, cmd_ready);
      end
   endtask

   task automatic test_reset();
      presetn   = 1'b0;
      cmd_valid = 1'b0;
      cmd_instr = 8'h00;
      cmd_cnt   = 3'd0;
      cmd_data  = 40'd0;
      pready    = 1'b1;
      step();
      step();
      check_idle_outputs("reset_held");
      presetn = 1'b1;
      step();
      check_idle_outputs("reset_released");
   endtask

   // One command end to end. ws: wait states on the first ACCESS.
   // start_lat: WAIT_START cycles with pready high before it drops.
   // busy_len: cycles pready stays low once dropped.
   task automatic run_cmd(input logic [7:0] instr, input logic [2:0] cnt, input logic [39:0] data,
                          input int ws, input int start_lat, input int busy_len, input string tag);
      logic [7:0] exp_a[$];
      logic [7:0] exp_d[$];
      logic [7:0] got_a[$];
      logic [7:0] got_d[$];
      int  apb_cyc = 0, ws_left = ws, hold_bad = 0, prot_bad = 0, wait_bad = 0;
      int  n_done = 0, n_err = 0, ev_k = -1, k = 0, exp_k;
      bit  exp_err, in_wait = 0, in_wait_next = 0, fin = 0;

      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s_ready_before: cmd_ready=%b required 1", tag, cmd_ready);
      end
      cmd_valid = 1'b1;
      cmd_instr = instr;
      cmd_cnt   = cnt;
      cmd_data  = data;
      pready    = 1'b1;
      step();

      if (cnt > 5) begin
         cmd_valid = 1'b0;
         for (int c = 0; c < 5; c++) begin
            if (err) begin n_err++; if (ev_k < 0) ev_k = c; end
            if (psel || penable) prot_bad++;
            if (cmd_ready !== 1'b1 || done) wait_bad++;
            step();
         end
         checks++;
         if (n_err != 1 || ev_k != 0 || prot_bad != 0 || wait_bad != 0) begin
            failures++;
            $display("FAIL %s_illegal: err_pulses=%0d at=%0d apb=%0d rdy_bad=%0d, required 1 at 0, 0, 0",
                     tag, n_err, ev_k, prot_bad, wait_bad);
         end
         return;
      end

      exp_a.push_back(8'h00); exp_d.push_back(instr);
      for (int a = 1; a <= int'(cnt); a++) begin
         exp_a.push_back(8'(a)); exp_d.push_back(data[8*(a-1) +: 8]);
      end
      exp_a.push_back(8'h06); exp_d.push_back({5'd0, cnt});
      exp_a.push_back(8'h07); exp_d.push_back(8'hFF);

      if (start_lat >= START_TMO) begin
         exp_err = 1; exp_k = START_TMO;
      end else if (busy_len > DONE_TMO) begin
         exp_err = 1; exp_k = start_lat + 1 + DONE_TMO;
      end else begin
         exp_err = 0; exp_k = start_lat + busy_len + 1;
      end

      // garbage command held valid while busy must be ignored
      cmd_valid = 1'b1;
      cmd_cnt   = 3'($urandom_range(0, 5));
      cmd_instr = 8'($urandom);

      for (int c = 0; c < 400 && !fin; c++) begin
         if (!in_wait) begin
            if (psel) begin
               apb_cyc++;
               if (pwrite !== 1'b1) prot_bad++;
               if (penable) begin
                  if (got_a.size() == 0 && ws_left > 0) begin
                     ws_left--;
                     pready = 1'b0;
                     if (paddr !== 8'h00 || pwdata !== instr) hold_bad++;
                  end else begin
                     pready = 1'b1;
                     got_a.push_back(paddr);
                     got_d.push_back(pwdata);
                     if (paddr == 8'h07) begin
                        in_wait_next = 1;
                        cmd_valid    = 1'b0;
                     end
                  end
               end else begin
                  pready = 1'b1;
               end
            end
         end else begin
            pready = (k < start_lat || k >= start_lat + busy_len) ? 1'b1 : 1'b0;
            if (psel || penable || pwrite) prot_bad++;
            if (k < exp_k && busy !== 1'b1) wait_bad++;
            if (k == exp_k && (busy !== 1'b0 || cmd_ready !== 1'b1)) wait_bad++;
            if (done) begin n_done++; if (ev_k < 0) ev_k = k; end
            if (err)  begin n_err++;  if (ev_k < 0) ev_k = k; end
            if (k >= exp_k + 2) fin = 1;
            k++;
         end
         step();
         if (in_wait_next) in_wait = 1;
      end
      cmd_valid = 1'b0;
      pready    = 1'b1;

      checks++;
      if (!fin) begin
         failures++;
         $display("FAIL %s_timeout: sequence did not finish within cycle budget (writes seen %0d)",
                  tag, got_a.size());
      end
      checks++;
      if (got_a.size() != exp_a.size()) begin
         failures++;
         $display("FAIL %s_write_count: got %0d writes, required %0d", tag, got_a.size(), exp_a.size());
      end
      for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
         checks++;
         if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin
            failures++;
            $display("FAIL %s_write%0d: got (%h,%h) required (%h,%h)",
                     tag, i, got_a[i], got_d[i], exp_a[i], exp_d[i]);
         end
      end
      checks++;
      if (apb_cyc != 2 * (int'(cnt) + 3) + ws || hold_bad != 0 || prot_bad != 0) begin
         failures++;
         $display("FAIL %s_apb_timing: psel cycles=%0d hold_bad=%0d prot_bad=%0d, required %0d,0,0",
                  tag, apb_cyc, hold_bad, prot_bad, 2 * (int'(cnt) + 3) + ws);
      end
      checks++;
      if (n_done != (exp_err ? 0 : 1) || n_err != (exp_err ? 1 : 0) || ev_k != exp_k) begin
         failures++;
         $display("FAIL %s_outcome: done=%0d err=%0d at k=%0d, required done=%0d err=%0d at k=%0d",
                  tag, n_done, n_err, ev_k, exp_err ? 0 : 1, exp_err ? 1 : 0, exp_k);
      end
      checks++;
      if (wait_bad != 0 || cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s_busy: busy/ready violations=%0d final ready=%b, required 0 and 1",
                  tag, wait_bad, cmd_ready);
      end
   endtask

   task automatic test_directed();
      run_cmd(8'h03, 3'd2, 40'h00_0000_BBAA, 0, 1, 12, "normal");
      run_cmd(8'h06, 3'd0, 40'h12_3456_789A, 0, 1, 3, "zero_cnt");
      run_cmd(8'h5A, 3'd6, 40'h0, 0, 0, 1, "illegal6");
      run_cmd(8'hA5, 3'd7, 40'h0, 0, 0, 1, "illegal7");
      run_cmd(8'h9F, 3'd5, 40'h55_4433_2211, 0, 1, 4, "full_cnt");
   endtask

   task automatic test_timeouts();
      run_cmd(8'h0B, 3'd3, 40'h00_00CC_BBAA, 0, 1000, 1, "start_tmo");
      run_cmd(8'h0B, 3'd1, 40'h77, 0, START_TMO - 1, 2, "start_edge_ok");
      run_cmd(8'h02, 3'd2, 40'h00_0000_2211, 2, 0, 1000, "done_tmo_ws");
      run_cmd(8'h02, 3'd1, 40'h33, 0, 0, DONE_TMO, "done_edge_ok");
      run_cmd(8'h02, 3'd1, 40'h33, 0, 0, DONE_TMO + 1, "done_edge_tmo");
   endtask

   task automatic test_reset_mid_write();
      bit seen = 0;
      cmd_valid = 1'b1;
      cmd_instr = 8'hC3;
      cmd_cnt   = 3'd3;
      cmd_data  = 40'h00_00EE_DDCC;
      pready    = 1'b1;
      step();
      cmd_valid = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         if (psel && penable && paddr == 8'h01) seen = 1;
         else step();
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL rst_mid_reach: ACCESS of address 01 not reached, required within 20 cycles");
      end
      presetn = 1'b0;
      step();
      check_idle_outputs("rst_mid_write");
      presetn = 1'b1;
      step();
      run_cmd(8'h44, 3'd1, 40'h99, 0, 2, 5, "after_reset");
   endtask

   task automatic test_random();
      for (int n = 0; n < 16; n++) begin
         logic [39:0] d;
         d = {8'($urandom), 32'($urandom)};
         run_cmd(8'($urandom), 3'($urandom_range(0, 7)), d, $urandom_range(0, 2),
                 $urandom_range(0, 5), $urandom_range(1, 20), $sformatf("rand%0d", n));
      end
   endtask

   task automatic test_back_to_back();
      run_cmd(8'h01, 3'd4, 40'h00_4433_2211, 1, 0, 1, "b2b_a");
      run_cmd(8'h02, 3'd6, 40'h0, 0, 0, 1, "b2b_b");
      run_cmd(8'h03, 3'd0, 40'h0, 0, 0, 1, "b2b_c");
   endtask

   initial begin
      test_reset();
      test_directed();
      test_timeouts();
      test_reset_mid_write();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
